// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle for mem_access_ctrl.
//   req_valid/req_ready : request handshake. A request is accepted when both are high at a clock edge.
//   req_we              : 1 = store, 0 = load.
//   req_addr/req_wdata  : request address and store data.
//   rsp_done            : one-cycle completion pulse.
//   rsp_rdata           : load result. It holds until the next load completes.
// Modports: master = CPU datapath, slave = controller.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_done;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_done, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_done, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for one data port of the shared memory.
// The controller sequences a single load or store per request.
//   A store takes the states IDLE -> ACCESS.
//   A load takes the states IDLE -> ACCESS -> CAPTURE.
// The memory writes on the clock edge and registers the read address, so load data is valid in CAPTURE.
// A load with address MSB set returns the synchronized switches instead of memory data.
// Ports:
//   clk       : system clock. All logic runs on posedge.
//   reset     : synchronous, active-high reset.
//   bus       : CPU request/response bundle (slave side).
//   mem_addr  : memory address port.
//   mem_din   : memory data-in port.
//   mem_we    : memory write enable.
//   mem_dout  : memory data-out, combinational from the registered read address.
//   switches  : asynchronous board switches.
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_access_ctrl_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic [DATA_WIDTH-1:0] switches
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                state;
  logic                  io_sel;
  logic                  rsp_done;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [DATA_WIDTH-1:0] sw_meta;
  logic [DATA_WIDTH-1:0] sw_sync;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_done  = rsp_done;
  assign bus.rsp_rdata = rsp_rdata;

  // Two-flop synchronizer for the asynchronous switches.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the address and data registers are reset as well.
      // They drive the memory port directly, so they must never start out as X.
      state     <= IDLE;
      rsp_done  <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      io_sel    <= 1'b0;
    end else begin
      rsp_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            mem_addr <= bus.req_addr;
            mem_din  <= bus.req_wdata;
            mem_we   <= bus.req_we;
            io_sel   <= bus.req_addr[ADDR_WIDTH-1];
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // The memory samples the port on this edge.
          // For a store, the write is committed here and the store is complete.
          mem_we <= 1'b0;
          if (mem_we) begin
            rsp_done <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_rdata <= io_sel ? sw_sync : mem_dout;
          rsp_done  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller for one data port of the shared 16-bit memory.
- The memory writes on the clock edge and registers the read address, so read data appears one cycle after the address is captured.
- Accepts single load/store requests from the CPU datapath over a valid/ready handshake and sequences the memory port (address, write data, write enable).
- Returns read data with a done pulse. For reads with address bit [ADDR_WIDTH-1] set, returns the synchronized switch inputs, which is the input direction of the memory-mapped LED region.

Parameters:
- DATA_WIDTH, 16, word width of data and switch paths.
- ADDR_WIDTH, 16, address width; bit ADDR_WIDTH-1 selects the I/O region.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  controller can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  store data.
- rsp_done  output  1  one-cycle pulse when the transaction completes.
- rsp_rdata  output  DATA_WIDTH  load result; holds until the next load completes.
- mem_addr  output  ADDR_WIDTH  to memory address port.
- mem_din  output  DATA_WIDTH  to memory data-in port.
- mem_we  output  1  to memory write enable.
- mem_dout  input  DATA_WIDTH  from memory data-out (combinational from the registered address).
- switches  input  DATA_WIDTH  asynchronous board switches.

Behaviour:
- Reset values: state IDLE, req_ready 1 (combinational from state), rsp_done 0, rsp_rdata 0, mem_addr 0, mem_din 0, mem_we 0, switch synchronizer flops 0.
- States: IDLE, ACCESS, CAPTURE.
- IDLE:
  - Accept on the edge where req_valid && req_ready.
  - On accept: register mem_addr<=req_addr, mem_din<=req_wdata, mem_we<=req_we, latch io_sel<=req_addr[ADDR_WIDTH-1], go to ACCESS.
  - With no request, mem_we stays 0 and the address/data registers hold their values.
- ACCESS (exactly one cycle):
  - Outputs are stable; the memory samples them on the closing edge.
  - On a store: the closing edge clears mem_we, pulses rsp_done, and returns to IDLE. The store is committed at that edge.
  - On a load: the closing edge clears mem_we (already 0) and moves to CAPTURE.
- CAPTURE (exactly one cycle):
  - The closing edge sets rsp_rdata <= io_sel ? sw_sync : mem_dout, pulses rsp_done, and returns to IDLE.
- Latency from the accept edge:
  - Store: rsp_done high in the cycle after the second edge. Throughput is one store per 2 cycles.
  - Load: rsp_done and valid rsp_rdata appear together after the third edge. Throughput is one load per 3 cycles.
- Back-to-back requests: req_valid held high is re-accepted on the first edge in IDLE. The cycle in which rsp_done is high is an IDLE cycle, so accept may coincide with it.
- Requests while busy: req_valid while not in IDLE is ignored. Inputs are not latched and there is no queue; the CPU must hold req_* until it is accepted.
- I/O stores: mem_we is still asserted normally, because the memory performs the LED routing. The controller does not special-case stores.
- I/O loads: mem_addr is still driven, and mem_dout is ignored.
- Switch path: sw_sync is the output of a 2-flop synchronizer on switches, sampled at the CAPTURE edge. A switch change therefore appears at most 2 cycles later.
- rsp_done: never high for two consecutive cycles, and never high without a preceding accept.
- Reset mid-transaction: on the reset edge go to IDLE, mem_we to 0 and rsp_done to 0, and discard any pending load. The aborted transaction produces no rsp_done.
- Simultaneous reset and req_valid: reset wins and the request is not accepted.
- Widths: no arithmetic; addresses pass through unmodified. Wrap-around is not applicable.

Test Plan:
- Reset held 2 cycles, then released -> all outputs at reset values, req_ready=1, mem_we=0.
- Store addr 0x0010, data 0xBEEF, then load 0x0010 -> mem_we high for exactly 1 cycle with mem_addr=0x0010 and mem_din=0xBEEF; rsp_done 2 cycles after the store accept; load returns rsp_rdata=0xBEEF with rsp_done 3 cycles after its accept.
- switches=0x00A5, load 0x8003 -> rsp_rdata=0x00A5 regardless of the memory contents at 0x8003. Changing switches to 0x5A00 and re-loading 3+ cycles later -> 0x5A00.
- req_valid held high with alternating store/load for 10 requests -> accepts only in IDLE; accept gaps of 2 cycles after stores and 3 after loads; exactly 10 rsp_done pulses; no lost or duplicated requests.
- Load accepted, then reset asserted in the ACCESS cycle -> no rsp_done, rsp_rdata=0, state IDLE, req_ready=1 on the next cycle.
- req_valid raised in ACCESS with different req_addr, then dropped before IDLE -> no accept; mem_addr unchanged; rsp_done only for the original transaction.
